// File: rtl/mpe_pkg.sv
// Shared types and constants for the matrix PE sequencer.
// The command struct uses MPE_ADDR_W, so mpe_seq must be built with ADDR_W equal to it.
package mpe_pkg;

  localparam int MPE_ADDR_W = 12;
  localparam logic [7:0] UOP_MAC = 8'h01;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    UOP      = 3'd1,
    STREAM   = 3'd2,
    WAIT_RES = 3'd3,
    FIN      = 3'd4
  } state_t;

  typedef struct packed {
    logic [MPE_ADDR_W-1:0] nram_base;
    logic [MPE_ADDR_W-1:0] wram_base;
    logic [MPE_ADDR_W-1:0] out_base;
    logic [15:0]           out_num;
    logic [7:0]            acc_len;
  } cmd_t;

endpackage

// File: rtl/mpe_stage.sv
// One-beat staging register between a RAM read port and a PE valid/ready stream.
module mpe_stage #(
  parameter int DATA_W = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap,
  input  logic [DATA_W-1:0] cap_data,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic              valid
);

  // capture returned read data; drop valid once the PE takes the beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (cap) begin
      data  <= cap_data;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mpe_seq.sv
// Matrix-vector command sequencer: issues MAC uops, streams NRAM/WRAM beats to the PE,
// and writes each PE result to the output buffer.
module mpe_seq
  import mpe_pkg::*;
#(
  parameter int ADDR_W = MPE_ADDR_W,
  parameter int DATA_W = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_nram_base,
  input  logic [ADDR_W-1:0] cmd_wram_base,
  input  logic [ADDR_W-1:0] cmd_out_base,
  input  logic [15:0]       cmd_out_num,
  input  logic [7:0]        cmd_acc_len,
  output logic              nram_rd_en,
  output logic [ADDR_W-1:0] nram_rd_addr,
  input  logic [DATA_W-1:0] nram_rd_data,
  output logic              wram_rd_en,
  output logic [ADDR_W-1:0] wram_rd_addr,
  input  logic [DATA_W-1:0] wram_rd_data,
  output logic [DATA_W-1:0] mpe_neuron,
  output logic              mpe_neuron_valid,
  input  logic              mpe_neuron_ready,
  output logic [DATA_W-1:0] mpe_weight,
  output logic              mpe_weight_valid,
  input  logic              mpe_weight_ready,
  output logic [7:0]        mpe_uop,
  output logic              mpe_uop_valid,
  input  logic              mpe_uop_ready,
  input  logic [31:0]       mpe_result,
  input  logic              mpe_vld,
  output logic              out_wr_en,
  output logic [ADDR_W-1:0] out_wr_addr,
  output logic [31:0]       out_wr_data,
  output logic              busy,
  output logic              done,
  output logic              err_stray
);

  state_t      state_r, next_state_s;
  cmd_t        cmd_r;
  logic [15:0] j_r, j_inc_s;
  logic [7:0]  k_r;
  logic        pend_r;
  logic [ADDR_W-1:0] wram_off_s;
  logic        cmd_fire_s, zero_work_s, quiet_s, issue_s, stream_end_s, res_s;

  assign cmd_fire_s  = cmd_valid && cmd_ready;
  assign zero_work_s = (cmd_out_num == 16'd0) || (cmd_acc_len == 8'd0);
  // Quiet means nothing in flight and both staging slots empty after this edge,
  // which lets the next read go out right as the previous beat is consumed.
  assign quiet_s = !nram_rd_en && !pend_r &&
                   (!mpe_neuron_valid || mpe_neuron_ready) &&
                   (!mpe_weight_valid || mpe_weight_ready);
  assign issue_s      = (state_r == STREAM) && quiet_s && (k_r != cmd_r.acc_len);
  assign stream_end_s = (state_r == STREAM) && quiet_s && (k_r == cmd_r.acc_len);
  assign res_s        = (state_r == WAIT_RES) && mpe_vld;
  assign j_inc_s      = j_r + 16'd1;
  assign wram_off_s   = ADDR_W'({8'd0, j_r} * {16'd0, cmd_r.acc_len});

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (cmd_fire_s) begin
          if (zero_work_s) next_state_s = FIN;
          else             next_state_s = UOP;
        end else begin
          next_state_s = IDLE;
        end
      end
      UOP: begin
        if (mpe_uop_valid && mpe_uop_ready) next_state_s = STREAM;
        else                                next_state_s = UOP;
      end
      STREAM: begin
        if (stream_end_s) next_state_s = WAIT_RES;
        else              next_state_s = STREAM;
      end
      WAIT_RES: begin
        if (res_s) begin
          if (j_inc_s == cmd_r.out_num) next_state_s = FIN;
          else                          next_state_s = UOP;
        end else begin
          next_state_s = WAIT_RES;
        end
      end
      FIN:     next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // command latch and beat/result counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_r <= '0;
      j_r   <= 16'd0;
      k_r   <= 8'd0;
    end else if (cmd_fire_s) begin
      cmd_r.nram_base <= cmd_nram_base;
      cmd_r.wram_base <= cmd_wram_base;
      cmd_r.out_base  <= cmd_out_base;
      cmd_r.out_num   <= cmd_out_num;
      cmd_r.acc_len   <= cmd_acc_len;
      j_r             <= 16'd0;
      k_r             <= 8'd0;
    end else if (res_s) begin
      j_r <= j_inc_s;
      k_r <= 8'd0;
    end else if (issue_s) begin
      k_r <= k_r + 8'd1;
    end
  end

  // paired NRAM/WRAM read issue; pend_r marks the cycle the data returns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nram_rd_en   <= 1'b0;
      wram_rd_en   <= 1'b0;
      nram_rd_addr <= '0;
      wram_rd_addr <= '0;
      pend_r       <= 1'b0;
    end else begin
      nram_rd_en <= issue_s;
      wram_rd_en <= issue_s;
      pend_r     <= nram_rd_en;
      if (issue_s) begin
        nram_rd_addr <= cmd_r.nram_base + ADDR_W'(k_r);
        wram_rd_addr <= cmd_r.wram_base + wram_off_s + ADDR_W'(k_r);
      end
    end
  end

  mpe_stage #(.DATA_W(DATA_W)) u_neuron_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .cap      (pend_r),
    .cap_data (nram_rd_data),
    .ready    (mpe_neuron_ready),
    .data     (mpe_neuron),
    .valid    (mpe_neuron_valid)
  );

  mpe_stage #(.DATA_W(DATA_W)) u_weight_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .cap      (pend_r),
    .cap_data (wram_rd_data),
    .ready    (mpe_weight_ready),
    .data     (mpe_weight),
    .valid    (mpe_weight_valid)
  );

  // control/status outputs registered from the next state so they line up with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready     <= 1'b0;
      busy          <= 1'b0;
      mpe_uop_valid <= 1'b0;
      mpe_uop       <= 8'h00;
      done          <= 1'b0;
      out_wr_en     <= 1'b0;
      out_wr_addr   <= '0;
      out_wr_data   <= 32'd0;
      err_stray     <= 1'b0;
    end else begin
      cmd_ready     <= (next_state_s == IDLE);
      busy          <= (next_state_s != IDLE);
      mpe_uop_valid <= (next_state_s == UOP);
      mpe_uop       <= (next_state_s == UOP) ? UOP_MAC : 8'h00;
      done          <= (state_r == FIN);
      out_wr_en     <= res_s;
      if (res_s) begin
        out_wr_addr <= cmd_r.out_base + ADDR_W'(j_r);
        out_wr_data <= mpe_result;
      end
      if (cmd_fire_s) begin
        err_stray <= 1'b0;
      end else if (mpe_vld && (state_r != WAIT_RES)) begin
        err_stray <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mpe_seq.sv
// Directed self-checking bench for mpe_seq: RAM models, PE result driver and
// monitors that log every handshake for later comparison.
module tb_mpe_seq;
  import mpe_pkg::*;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 512;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid, cmd_ready;
  logic [ADDR_W-1:0] cmd_nram_base, cmd_wram_base, cmd_out_base;
  logic [15:0]       cmd_out_num;
  logic [7:0]        cmd_acc_len;
  logic              nram_rd_en, wram_rd_en;
  logic [ADDR_W-1:0] nram_rd_addr, wram_rd_addr;
  logic [DATA_W-1:0] nram_rd_data, wram_rd_data;
  logic [DATA_W-1:0] mpe_neuron, mpe_weight;
  logic              mpe_neuron_valid, mpe_neuron_ready;
  logic              mpe_weight_valid, mpe_weight_ready;
  logic [7:0]        mpe_uop;
  logic              mpe_uop_valid, mpe_uop_ready;
  logic [31:0]       mpe_result;
  logic              mpe_vld;
  logic              out_wr_en;
  logic [ADDR_W-1:0] out_wr_addr;
  logic [31:0]       out_wr_data;
  logic              busy, done, err_stray;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n0, u0, o0, d0, a0;

  logic [ADDR_W-1:0] nr_q[$], wr_q[$], oa_q[$];
  logic [DATA_W-1:0] nb_q[$], wb_q[$];
  logic [31:0]       od_q[$];
  logic [7:0]        uop_q[$];
  int                rd_cyc_q[$], acc_q[$], done_q[$], ow_cyc_q[$];

  always #5 clk = ~clk;

  mpe_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_nram_base(cmd_nram_base), .cmd_wram_base(cmd_wram_base), .cmd_out_base(cmd_out_base),
    .cmd_out_num(cmd_out_num), .cmd_acc_len(cmd_acc_len),
    .nram_rd_en(nram_rd_en), .nram_rd_addr(nram_rd_addr), .nram_rd_data(nram_rd_data),
    .wram_rd_en(wram_rd_en), .wram_rd_addr(wram_rd_addr), .wram_rd_data(wram_rd_data),
    .mpe_neuron(mpe_neuron), .mpe_neuron_valid(mpe_neuron_valid), .mpe_neuron_ready(mpe_neuron_ready),
    .mpe_weight(mpe_weight), .mpe_weight_valid(mpe_weight_valid), .mpe_weight_ready(mpe_weight_ready),
    .mpe_uop(mpe_uop), .mpe_uop_valid(mpe_uop_valid), .mpe_uop_ready(mpe_uop_ready),
    .mpe_result(mpe_result), .mpe_vld(mpe_vld),
    .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data),
    .busy(busy), .done(done), .err_stray(err_stray)
  );

  function automatic logic [DATA_W-1:0] pat(input logic [3:0] tag, input logic [ADDR_W-1:0] a);
    return {tag, 496'd0, a};
  endfunction

  // RAM models: data one cycle after rd_en, all-ones garbage otherwise
  always @(posedge clk) begin
    nram_rd_data <= nram_rd_en ? pat(4'hA, nram_rd_addr) : {DATA_W{1'b1}};
    wram_rd_data <= wram_rd_en ? pat(4'hB, wram_rd_addr) : {DATA_W{1'b1}};
  end

  // handshake monitors
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (nram_rd_en) begin
      nr_q.push_back(nram_rd_addr);
      rd_cyc_q.push_back(cyc);
    end
    if (wram_rd_en) wr_q.push_back(wram_rd_addr);
    if (mpe_uop_valid && mpe_uop_ready) uop_q.push_back(mpe_uop);
    if (mpe_neuron_valid && mpe_neuron_ready) nb_q.push_back(mpe_neuron);
    if (mpe_weight_valid && mpe_weight_ready) wb_q.push_back(mpe_weight);
    if (out_wr_en) begin
      oa_q.push_back(out_wr_addr);
      od_q.push_back(out_wr_data);
      ow_cyc_q.push_back(cyc);
    end
    if (done) done_q.push_back(cyc);
    if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    n0 = nr_q.size();
    u0 = uop_q.size();
    o0 = oa_q.size();
    d0 = done_q.size();
    a0 = acc_q.size();
  endtask

  task automatic send(input logic [ADDR_W-1:0] nb, input logic [ADDR_W-1:0] wb,
                      input logic [ADDR_W-1:0] ob, input logic [15:0] jn, input logic [7:0] kl);
    int t = 0;
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("send_cmd_ready", cmd_ready, 32'd1);
    cmd_nram_base = nb;
    cmd_wram_base = wb;
    cmd_out_base  = ob;
    cmd_out_num   = jn;
    cmd_acc_len   = kl;
    cmd_valid     = 1'b1;
    @(negedge clk);
    cmd_valid     = 1'b0;
  endtask

  // wait for each result's K beats on both channels, then return the PE result
  task automatic pe_results(input int jn, input int kl, input bit bp, input logic [31:0] rbase);
    int nb0 = nb_q.size();
    int wb0 = wb_q.size();
    for (int j = 0; j < jn; j++) begin
      int t = 0;
      while ((nb_q.size() < nb0 + (j + 1) * kl || wb_q.size() < wb0 + (j + 1) * kl) && t < 300) begin
        if (bp) begin
          mpe_neuron_ready = ($urandom_range(1, 0) != 0);
          mpe_weight_ready = ($urandom_range(1, 0) != 0);
        end else begin
          mpe_neuron_ready = 1'b1;
          mpe_weight_ready = 1'b1;
        end
        @(negedge clk);
        t++;
      end
      chk("beats_before_result", {31'd0, t < 300}, 32'd1);
      mpe_neuron_ready = 1'b1;
      mpe_weight_ready = 1'b1;
      mpe_vld    = 1'b1;
      mpe_result = rbase + 32'(j);
      @(negedge clk);
      mpe_vld    = 1'b0;
    end
  endtask

  task automatic wait_done();
    int t = 0;
    while (done_q.size() <= d0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", {31'd0, done_q.size() > d0}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_nram_base = '0;
    cmd_wram_base = '0;
    cmd_out_base = '0;
    cmd_out_num = 16'd0;
    cmd_acc_len = 8'd0;
    mpe_neuron_ready = 1'b1;
    mpe_weight_ready = 1'b1;
    mpe_uop_ready = 1'b1;
    mpe_vld = 1'b0;
    mpe_result = 32'd0;
    repeat (3) @(negedge clk);

    chk("rst_cmd_ready", cmd_ready, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_done", done, 32'd0);
    chk("rst_rd_en", nram_rd_en, 32'd0);
    chk("rst_uop_valid", mpe_uop_valid, 32'd0);
    chk("rst_out_wr_en", out_wr_en, 32'd0);
    chk("rst_err_stray", err_stray, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_reset", cmd_ready, 32'd1);

    // J=1, K=3, all bases zero
    snap();
    send(12'd0, 12'd0, 12'd0, 16'd1, 8'd3);
    chk("t1_uop_valid_at_T1", mpe_uop_valid, 32'd1);
    chk("t1_busy", busy, 32'd1);
    pe_results(1, 3, 1'b0, 32'h1111_0000);
    wait_done();
    repeat (3) @(negedge clk);
    chk("t1_nram_reads", nr_q.size() - n0, 32'd3);
    chk("t1_wram_reads", wr_q.size() - n0, 32'd3);
    for (int k = 0; k < 3; k++) begin
      chk("t1_nram_addr", nr_q[n0 + k], k);
      chk("t1_wram_addr", wr_q[n0 + k], k);
      chk_w("t1_neuron_beat", nb_q[n0 + k], pat(4'hA, ADDR_W'(k)));
      chk_w("t1_weight_beat", wb_q[n0 + k], pat(4'hB, ADDR_W'(k)));
    end
    chk("t1_read_spacing", rd_cyc_q[n0 + 1] - rd_cyc_q[n0], 32'd3);
    chk("t1_uops", uop_q.size() - u0, 32'd1);
    chk("t1_uop_code", uop_q[u0], 32'h01);
    chk("t1_writes", oa_q.size() - o0, 32'd1);
    chk("t1_write_addr", oa_q[o0], 32'd0);
    chk("t1_write_data", od_q[o0], 32'h1111_0000);
    chk("t1_done_count", done_q.size() - d0, 32'd1);
    chk("t1_done_after_write", done_q[d0] - ow_cyc_q[o0], 32'd1);

    // J=4, K=2, nram 5, wram 10, out 100
    snap();
    send(12'd5, 12'd10, 12'd100, 16'd4, 8'd2);
    pe_results(4, 2, 1'b0, 32'h2222_0000);
    wait_done();
    repeat (3) @(negedge clk);
    chk("t2_reads", wr_q.size() - n0, 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("t2_wram_addr", wr_q[n0 + i], 10 + i);
      chk("t2_nram_addr", nr_q[n0 + i], 5 + (i % 2));
    end
    chk("t2_uops", uop_q.size() - u0, 32'd4);
    chk("t2_writes", oa_q.size() - o0, 32'd4);
    for (int j = 0; j < 4; j++) begin
      chk("t2_write_addr", oa_q[o0 + j], 100 + j);
      chk("t2_write_data", od_q[o0 + j], 32'h2222_0000 + 32'(j));
    end
    chk("t2_done_count", done_q.size() - d0, 32'd1);

    // zero-work commands: J=0 then K=0
    for (int z = 0; z < 2; z++) begin
      snap();
      if (z == 0) send(12'd1, 12'd2, 12'd3, 16'd0, 8'd5);
      else        send(12'd1, 12'd2, 12'd3, 16'd3, 8'd0);
      wait_done();
      @(negedge clk);
      chk("t3_done_latency", done_q[d0] - acc_q[a0], 32'd2);
      chk("t3_no_reads", nr_q.size() - n0, 32'd0);
      chk("t3_no_uop", uop_q.size() - u0, 32'd0);
      chk("t3_no_write", oa_q.size() - o0, 32'd0);
      chk("t3_cmd_ready", cmd_ready, 32'd1);
    end

    // independent random backpressure, J=2, K=5
    snap();
    send(12'h020, 12'h040, 12'h200, 16'd2, 8'd5);
    pe_results(2, 5, 1'b1, 32'h4444_0000);
    wait_done();
    repeat (3) @(negedge clk);
    chk("t4_neuron_beats", nb_q.size() - n0, 32'd10);
    chk("t4_weight_beats", wb_q.size() - n0, 32'd10);
    for (int i = 0; i < 10; i++) begin
      chk_w("t4_neuron_order", nb_q[n0 + i], pat(4'hA, ADDR_W'(32 + (i % 5))));
      chk_w("t4_weight_order", wb_q[n0 + i], pat(4'hB, ADDR_W'(64 + i)));
    end
    chk("t4_writes", oa_q.size() - o0, 32'd2);
    chk("t4_write_addr1", oa_q[o0 + 1], 32'h201);
    chk("t4_write_data1", od_q[o0 + 1], 32'h4444_0001);

    // stray mpe_vld during STREAM
    snap();
    mpe_neuron_ready = 1'b0;
    mpe_weight_ready = 1'b0;
    send(12'd0, 12'd0, 12'd8, 16'd1, 8'd3);
    begin
      int t = 0;
      while (!mpe_neuron_valid && t < 50) begin
        @(negedge clk);
        t++;
      end
      chk("t5_in_stream", mpe_neuron_valid, 32'd1);
    end
    mpe_vld = 1'b1;
    mpe_result = 32'hBAD0_BAD0;
    @(negedge clk);
    mpe_vld = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_err_stray_set", err_stray, 32'd1);
    chk("t5_no_stray_write", oa_q.size() - o0, 32'd0);
    pe_results(1, 3, 1'b0, 32'h5555_0000);
    wait_done();
    @(negedge clk);
    chk("t5_err_stray_sticky", err_stray, 32'd1);
    chk("t5_writes", oa_q.size() - o0, 32'd1);
    chk("t5_write_data", od_q[o0], 32'h5555_0000);
    snap();
    send(12'd0, 12'd0, 12'd0, 16'd0, 8'd1);
    chk("t5_err_stray_cleared", err_stray, 32'd0);
    wait_done();

    // reset mid-STREAM with a read in flight
    snap();
    send(12'd0, 12'd0, 12'd0, 16'd3, 8'd4);
    begin
      int t = 0;
      while (!(nram_rd_en && nb_q.size() > n0) && t < 100) begin
        @(negedge clk);
        t++;
      end
      chk("t6_read_in_flight", nram_rd_en, 32'd1);
    end
    rst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 32'd0);
    chk("t6_cmd_ready", cmd_ready, 32'd0);
    chk("t6_rd_en", nram_rd_en, 32'd0);
    chk("t6_rd_addr", nram_rd_addr, 32'd0);
    chk("t6_neuron_valid", mpe_neuron_valid, 32'd0);
    chk("t6_weight_valid", mpe_weight_valid, 32'd0);
    chk_w("t6_neuron_data", mpe_neuron, '0);
    chk("t6_uop_valid", mpe_uop_valid, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_ready_after_release", cmd_ready, 32'd1);
    snap();
    send(12'd7, 12'd20, 12'd50, 16'd1, 8'd2);
    pe_results(1, 2, 1'b0, 32'h6666_0000);
    wait_done();
    repeat (3) @(negedge clk);
    chk("t6_reads", nr_q.size() - n0, 32'd2);
    chk("t6_nram_addr0", nr_q[n0], 32'd7);
    chk("t6_wram_addr1", wr_q[n0 + 1], 32'd21);
    chk_w("t6_neuron_beat0", nb_q[nb_q.size() - 2], pat(4'hA, 12'd7));
    chk("t6_write_addr", oa_q[o0], 32'd50);
    chk("t6_write_data", od_q[o0], 32'h6666_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
